// File: rtl/arbiter_pkg.sv
// Shared interconnect definitions for the bus arbiter.
// Holds the default requester count and id-width helper.
package arbiter_pkg;

  localparam int NumCores = 4;

  // Index width never drops below one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbiter_priority_encoder.sv
// Lowest-index-wins priority encoder.
// Returns the isolated one-hot winner and its binary index.
module arbiter_priority_encoder
  import arbiter_pkg::*;
#(
  parameter int Width   = NumCores,
  parameter int IdWidth = id_width(Width)
) (
  input  logic [Width-1:0]   req,
  output logic [Width-1:0]   onehot,
  output logic [IdWidth-1:0] idx,
  output logic               found
);

  // Scan high to low so the lowest set bit is the last write.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IdWidth'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter.sv
// Fixed-priority registered bus arbiter, lowest index wins.
// Grant is a pure registered function of the previous REQ.
module arbiter
  import arbiter_pkg::*;
#(
  parameter int NumOfRequesters = NumCores,
  parameter int IdWidth         = id_width(NumOfRequesters)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NumOfRequesters-1:0] REQ,
  output logic [NumOfRequesters-1:0] ACCESS,
  output logic                       ACCESS_VALID,
  output logic [IdWidth-1:0]         ACCESS_ID
);

  logic [NumOfRequesters-1:0] pick;
  logic [IdWidth-1:0]         pick_id;
  logic                       pick_vld;

  arbiter_priority_encoder #(
    .Width   (NumOfRequesters),
    .IdWidth (IdWidth)
  ) u_enc (
    .req    (REQ),
    .onehot (pick),
    .idx    (pick_id),
    .found  (pick_vld)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      ACCESS       <= '0;
      ACCESS_VALID <= 1'b0;
      ACCESS_ID    <= '0;
    end else begin
      ACCESS       <= pick;
      ACCESS_VALID <= pick_vld;
      ACCESS_ID    <= pick_id;
    end
  end

endmodule

// File: tb/tb_arbiter.sv
// Bench for the fixed-priority arbiter: directed steps,
// then random REQ against an arithmetic model (N=4,1,5).
module tb_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;

  logic [3:0] req4 = '0;
  logic [3:0] acc4;
  logic       v4;
  logic [1:0] id4;

  logic       req1 = '0;
  logic       acc1;
  logic       v1;
  logic [0:0] id1;

  logic [4:0] req5 = '0;
  logic [4:0] acc5;
  logic       v5;
  logic [2:0] id5;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  arbiter #(.NumOfRequesters(4)) dut4 (
    .CLK(CLK), .RST(RST), .REQ(req4),
    .ACCESS(acc4), .ACCESS_VALID(v4), .ACCESS_ID(id4)
  );

  arbiter #(.NumOfRequesters(1)) dut1 (
    .CLK(CLK), .RST(RST), .REQ(req1),
    .ACCESS(acc1), .ACCESS_VALID(v1), .ACCESS_ID(id1)
  );

  arbiter #(.NumOfRequesters(5)) dut5 (
    .CLK(CLK), .RST(RST), .REQ(req5),
    .ACCESS(acc5), .ACCESS_VALID(v5), .ACCESS_ID(id5)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic rs);
    req4 = r;
    RST  = rs;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk4(input string tag,
                      input logic [3:0] acc,
                      input int id);
    check({tag, ".acc"}, 32'(acc4), 32'(acc));
    check({tag, ".vld"}, 32'(v4), 32'(acc != 0));
    check({tag, ".id"}, 32'(id4), 32'(id));
  endtask

  // Reference: isolate lowest set bit with two's complement,
  // index is log2 of that power of two.
  function automatic int model_oh(input int r, input bit rs);
    return rs ? 0 : (r & (-r));
  endfunction

  initial begin
    int r4, r1, r5, oh;
    bit rs;

    cyc(4'b1111, 1'b1);
    chk4("rst1", 4'b0000, 0);
    cyc(4'b1111, 1'b1);
    chk4("rst2", 4'b0000, 0);
    cyc(4'b1111, 1'b0);
    chk4("rel", 4'b0001, 0);

    cyc(4'b0110, 1'b0);
    chk4("sim", 4'b0010, 1);
    cyc(4'b0100, 1'b0);
    chk4("drop1", 4'b0100, 2);

    cyc(4'b0101, 1'b0);
    chk4("pre", 4'b0001, 0);
    cyc(4'b0001, 1'b0);
    chk4("pre_d2", 4'b0001, 0);
    cyc(4'b0000, 1'b0);
    chk4("pre_d0", 4'b0000, 0);

    cyc(4'b0100, 1'b0);
    chk4("ml2", 4'b0100, 2);
    cyc(4'b1100, 1'b0);
    chk4("ml3", 4'b0100, 2);
    cyc(4'b1110, 1'b0);
    chk4("ml1", 4'b0010, 1);
    cyc(4'b1010, 1'b0);
    chk4("ml_d2", 4'b0010, 1);
    cyc(4'b1000, 1'b0);
    chk4("ml_d1", 4'b1000, 3);
    cyc(4'b0000, 1'b0);
    chk4("ml_d3", 4'b0000, 0);

    cyc(4'b1000, 1'b0);
    chk4("mr_g", 4'b1000, 3);
    cyc(4'b1000, 1'b1);
    chk4("mr_rst", 4'b0000, 0);
    cyc(4'b1000, 1'b0);
    chk4("mr_back", 4'b1000, 3);

    for (int n = 0; n < 1000; n++) begin
      r4 = int'($urandom_range(0, 15));
      r1 = int'($urandom_range(0, 1));
      r5 = int'($urandom_range(0, 31));
      rs = ($urandom_range(0, 49) == 0);
      req4 = 4'(r4);
      req1 = 1'(r1);
      req5 = 5'(r5);
      RST  = rs;
      @(posedge CLK);
      #1;
      oh = model_oh(r4, rs);
      check("r4.acc", 32'(acc4), 32'(oh));
      check("r4.vld", 32'(v4), 32'(oh != 0));
      check("r4.id", 32'(id4), 32'($clog2(oh)));
      check("r4.oh0", 32'($onehot0(acc4)), 32'd1);
      oh = model_oh(r1, rs);
      check("r1.acc", 32'(acc1), 32'(oh));
      check("r1.vld", 32'(v1), 32'(oh != 0));
      check("r1.id", 32'(id1), 32'd0);
      oh = model_oh(r5, rs);
      check("r5.acc", 32'(acc5), 32'(oh));
      check("r5.vld", 32'(v5), 32'(oh != 0));
      check("r5.id", 32'(id5), 32'($clog2(oh)));
      check("r5.oh0", 32'($onehot0(acc5)), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
